// File: rtl/uart_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_reg_bridge
// Purpose  : Command responder between a UART receiver/transmitter pair and a
//            simple register bus. Decodes 'W' addr data and 'R' addr frames,
//            issues one register strobe per good frame, and replies with
//            ACK (0x06), NAK (0x15) or the read-data byte.
// Ports    : clk, rst (synchronous, active low)
//            rx_rdy / rx_data / rx_rdy_clr  - receiver byte handshake
//            tx_wr_en / tx_data / tx_busy   - transmitter byte handshake
//            reg_wr / reg_rd / reg_addr / reg_wdata / reg_rdata - register bus
//            frame_err (pulse on NAK or timeout), err_cnt (saturating count)
// Options  : UART_BRIDGE_CHECKSUM_EN - adds a trailing XOR checksum byte to
//            every request and a checksum byte after read data in the reply.
// Revision : 1.0 - initial release
// ============================================================================
module uart_reg_bridge #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              rx_rdy_clr,
  output logic              tx_wr_en,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              reg_wr,
  output logic              reg_rd,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              frame_err,
  output logic [7:0]        err_cnt
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_ADDR  = 3'd1;
  localparam logic [2:0] S_GET_DATA  = 3'd2;
  localparam logic [2:0] S_GET_CHK   = 3'd3;
  localparam logic [2:0] S_EXEC      = 3'd4;
  localparam logic [2:0] S_RD_WAIT   = 3'd5;
  localparam logic [2:0] S_SEND      = 3'd6;
  localparam logic [2:0] S_SEND_WAIT = 3'd7;

`ifdef UART_BRIDGE_CHECKSUM_EN
  localparam logic [2:0] S_BODY_DONE = S_GET_CHK;
`else
  localparam logic [2:0] S_BODY_DONE = S_EXEC;
`endif

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  // Address-byte bits that must be zero for the address to be legal.
  localparam logic [7:0] ADDR_HI_MASK = 8'(8'hFF << ADDR_W);

  localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]      state;
  logic            is_read;
  logic            skip;         // blocks re-accepting the byte just cleared
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      reply;
  logic            rd_pending;   // first SEND cycle of a read takes reg_rdata
  logic            nak_pending;  // raises frame_err on the first SEND cycle
  logic            wait_first;   // SEND_WAIT ignores tx_busy right after pulse
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [7:0]      chk;
  logic            chk_pending;
`endif

  logic            in_get;
  logic            accept;
  logic            addr_ok;
  logic [7:0]      send_byte;

  assign in_get    = (state == S_GET_ADDR) || (state == S_GET_DATA) ||
                     (state == S_GET_CHK);
  assign accept    = rx_rdy && !skip && ((state == S_IDLE) || in_get);
  assign addr_ok   = (rx_data & ADDR_HI_MASK) == 8'h00;
  assign send_byte = rd_pending ? reg_rdata : reply;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      is_read     <= 1'b0;
      skip        <= 1'b0;
      to_cnt      <= '0;
      reply       <= 8'h00;
      rd_pending  <= 1'b0;
      nak_pending <= 1'b0;
      wait_first  <= 1'b0;
      rx_rdy_clr  <= 1'b0;
      tx_wr_en    <= 1'b0;
      tx_data     <= 8'h00;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= 8'h00;
      frame_err   <= 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
      chk         <= 8'h00;
      chk_pending <= 1'b0;
`endif
    end else begin
      rx_rdy_clr <= accept;
      skip       <= accept;
      tx_wr_en   <= 1'b0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      frame_err  <= 1'b0;

      // Inter-byte timeout: only counts while a frame is partly received.
      if (in_get && !accept) begin
        if (to_cnt == TO_LAST) begin
          to_cnt    <= '0;
          state     <= S_IDLE;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
            chk <= rx_data;
`endif
            if (rx_data == CMD_W) begin
              is_read <= 1'b0;
              state   <= S_GET_ADDR;
            end else if (rx_data == CMD_R) begin
              is_read <= 1'b1;
              state   <= S_GET_ADDR;
            end else begin
              reply       <= NAK;
              nak_pending <= 1'b1;
              state       <= S_SEND;
            end
          end
        end
        S_GET_ADDR: begin
          if (accept) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
            chk <= chk ^ rx_data;
`endif
            if (!addr_ok) begin
              reply       <= NAK;
              nak_pending <= 1'b1;
              state       <= S_SEND;
            end else begin
              reg_addr <= rx_data[ADDR_W-1:0];
              state    <= is_read ? S_BODY_DONE : S_GET_DATA;
            end
          end
        end
        S_GET_DATA: begin
          if (accept) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
            chk <= chk ^ rx_data;
`endif
            reg_wdata <= rx_data;
            state     <= S_BODY_DONE;
          end
        end
`ifdef UART_BRIDGE_CHECKSUM_EN
        S_GET_CHK: begin
          if (accept) begin
            if (rx_data == chk) begin
              state <= S_EXEC;
            end else begin
              reply       <= NAK;
              nak_pending <= 1'b1;
              state       <= S_SEND;
            end
          end
        end
`endif
        S_EXEC: begin
          if (is_read) begin
            reg_rd <= 1'b1;
            state  <= S_RD_WAIT;
          end else begin
            reg_wr <= 1'b1;
            reply  <= ACK;
            state  <= S_SEND;
          end
        end
        S_RD_WAIT: begin
          // reg_rdata becomes valid during the following (SEND) cycle.
          rd_pending <= 1'b1;
          state      <= S_SEND;
        end
        S_SEND: begin
          if (rd_pending) begin
            // Latch read data once so a stalled send still has it.
            reply      <= reg_rdata;
            rd_pending <= 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
            chk         <= chk ^ reg_rdata;
            chk_pending <= 1'b1;
`endif
          end
          if (nak_pending) begin
            frame_err   <= 1'b1;
            nak_pending <= 1'b0;
          end
          if (!tx_busy) begin
            tx_wr_en   <= 1'b1;
            tx_data    <= send_byte;
            wait_first <= 1'b1;
            state      <= S_SEND_WAIT;
          end
        end
        S_SEND_WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!tx_busy) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
            if (chk_pending) begin
              reply       <= chk;
              chk_pending <= 1'b0;
              state       <= S_SEND;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt <= 8'h00;
    end else if (frame_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_reg_bridge
// Purpose  : Self-checking bench for uart_reg_bridge. Drives request frames
//            through a receiver handshake, plays the register block, records
//            every DUT strobe/pulse and compares against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_reg_bridge;

  localparam int         ADDR_W      = 4;
  localparam int         TIMEOUT_CYC = 200;
  localparam logic [7:0] ACK         = 8'h06;
  localparam logic [7:0] NAK         = 8'h15;
  localparam logic [7:0] CW          = 8'h57;
  localparam logic [7:0] CR          = 8'h52;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rx_rdy = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_rdy_clr;
  logic              tx_wr_en;
  logic [7:0]        tx_data;
  logic              tx_busy = 1'b0;
  logic              reg_wr;
  logic              reg_rd;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;
  logic              frame_err;
  logic [7:0]        err_cnt;

  always #5 clk = ~clk;

  uart_reg_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .rx_rdy_clr(rx_rdy_clr), .tx_wr_en(tx_wr_en), .tx_data(tx_data),
    .tx_busy(tx_busy), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .frame_err(frame_err),
    .err_cnt(err_cnt)
  );

  // Register block: read data valid the cycle after reg_rd.
  logic [7:0] dev_mem [16];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= 8'((i * 37 + 11) & 255);
      reg_rdata <= 8'h00;
    end else begin
      if (reg_rd) reg_rdata <= dev_mem[reg_addr];
      if (reg_wr) dev_mem[reg_addr] <= reg_wdata;
    end
  end

  // Event recorder, sampled mid-cycle.
  int         cyc = 0, clr_cnt = 0, rd_cnt = 0, err_pulses = 0, both_cnt = 0;
  int         last_clr = 0, last_wr = 0, last_rd = 0, last_err = 0;
  logic [7:0] tx_q [$];
  int         tx_cyc_q [$];
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];

  always @(negedge clk) begin
    cyc++;
    if (rx_rdy_clr) begin clr_cnt++; last_clr = cyc; end
    if (tx_wr_en) begin tx_q.push_back(tx_data); tx_cyc_q.push_back(cyc); end
    if (reg_wr) begin
      wr_addr_q.push_back(8'(reg_addr)); wr_data_q.push_back(reg_wdata); last_wr = cyc;
    end
    if (reg_rd) begin rd_cnt++; last_rd = cyc; end
    if (reg_wr && reg_rd) both_cnt++;
    if (frame_err) begin err_pulses++; last_err = cyc; end
  end

  int         errors = 0, checks = 0;
  logic [7:0] ref_mem [16];
  int         exp_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'((i * 37 + 11) & 255);
    exp_err = 0;
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    tx_q.delete(); tx_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
  endtask

  // Present one byte and hold it until the DUT acknowledges it.
  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    rx_data = b;
    rx_rdy  = 1'b1;
    do begin
      @(posedge clk); #1; k++;
    end while (!rx_rdy_clr && k < 400);
    checks++;
    assert (rx_rdy_clr === 1'b1) else begin
      errors++;
      $error("FAIL rx_accept observed=no_clear expected=clear byte=0x%0h", b);
    end
    @(posedge clk); #1;
    rx_rdy = 1'b0;
  endtask

  // Build a frame, predict its outcome from the protocol rules, run it, compare.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input bit timing);
    logic [7:0] fr [$];
    logic [7:0] exp_tx [$];
    logic [7:0] d, x;
    bit         exp_wr = 0, exp_rd = 0, exp_nak = 0;
    int         rd0, e0, c0, clr_at, k;
    fr.push_back(b0);
    if (b0 != CW && b0 != CR) begin
      exp_nak = 1;
    end else begin
      fr.push_back(b1);
      if ((b1 >> ADDR_W) != 8'h00) begin
        exp_nak = 1;
      end else begin
        if (b0 == CW) fr.push_back(b2);
`ifdef UART_BRIDGE_CHECKSUM_EN
        x = 8'h00;
        foreach (fr[i]) x = x ^ fr[i];
        fr.push_back(x);
`endif
        if (b0 == CW) begin
          exp_wr = 1;
          ref_mem[b1[ADDR_W-1:0]] = b2;
          exp_tx.push_back(ACK);
        end else begin
          exp_rd = 1;
          d = ref_mem[b1[ADDR_W-1:0]];
          exp_tx.push_back(d);
`ifdef UART_BRIDGE_CHECKSUM_EN
          exp_tx.push_back(CR ^ b1 ^ d);
`endif
        end
      end
    end
    if (exp_nak) begin exp_tx.push_back(NAK); bump_err(); end

    clear_log();
    rd0 = rd_cnt; e0 = err_pulses; c0 = clr_cnt;
    foreach (fr[i]) send_byte(fr[i]);
    clr_at = last_clr;
    k = 0;
    while (tx_q.size() < exp_tx.size() && k < 300) begin tick(1); k++; end
    tick(6);

    check("tx_count", tx_q.size(), exp_tx.size());
    foreach (exp_tx[i]) if (i < tx_q.size()) check("tx_byte", tx_q[i], exp_tx[i]);
    check("wr_count", wr_addr_q.size(), 32'(exp_wr));
    if (exp_wr && wr_addr_q.size() > 0) begin
      check("wr_addr", wr_addr_q[0], 8'(b1[ADDR_W-1:0]));
      check("wr_data", wr_data_q[0], b2);
    end
    check("rd_count", rd_cnt - rd0, 32'(exp_rd));
    check("err_pulses", err_pulses - e0, 32'(exp_nak));
    check("clr_count", clr_cnt - c0, fr.size());
    check("err_cnt", err_cnt, exp_err);
    check("strobe_overlap", both_cnt, 0);
    if (timing && tx_cyc_q.size() > 0) begin
      if (exp_wr) begin
        check("wr_latency", last_wr - clr_at, 1);
        check("ack_latency", tx_cyc_q[0] - clr_at, 2);
      end else if (exp_rd) begin
        check("rd_latency", last_rd - clr_at, 1);
        check("rdata_latency", tx_cyc_q[0] - clr_at, 3);
      end else begin
        check("nak_latency", tx_cyc_q[0] - clr_at, 1);
        check("err_latency", last_err - clr_at, 1);
      end
    end
  endtask

  initial begin
    int         c0, e0, k;
    logic [7:0] a, b;
    int         kind;

    // Reset held with a byte waiting: nothing may move.
    ref_reset();
    rst = 1'b0; rx_rdy = 1'b1; rx_data = CW;
    tick(6);
    check("rst_rx_rdy_clr", rx_rdy_clr, 1'b0);
    check("rst_tx_wr_en", tx_wr_en, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_reg_rd", reg_rd, 1'b0);
    check("rst_reg_addr", reg_addr, 4'h0);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_err_cnt", err_cnt, 8'h00);
    check("rst_clr_pulses", clr_cnt, 0);
    rx_rdy = 1'b0;
    rst = 1'b1;
    tick(2);

    // Directed frames with exact latency checks.
    run_frame(CW, 8'h05, 8'hA5, 1'b1);
    run_frame(CW, 8'h05, 8'h3C, 1'b1);
    run_frame(CR, 8'h05, 8'h00, 1'b1);
    run_frame(8'h41, 8'h00, 8'h00, 1'b1);
    run_frame(CW, 8'h10, 8'h77, 1'b1);
    run_frame(CR, 8'hF0, 8'h00, 1'b1);
    run_frame(CR, 8'h0F, 8'h00, 1'b1);

    // Partial frame then silence: timeout, no reply, no access.
    clear_log();
    e0 = err_pulses;
    send_byte(CW);
    send_byte(8'h05);
    c0 = last_clr;
    tick(TIMEOUT_CYC + 20);
    bump_err();
    check("to_err_pulse", err_pulses - e0, 1);
    check("to_tx_count", tx_q.size(), 0);
    check("to_wr_count", wr_addr_q.size(), 0);
    check("to_window", ((last_err - c0) >= TIMEOUT_CYC - 1) && ((last_err - c0) <= TIMEOUT_CYC + 1), 1'b1);
    check("to_err_cnt", err_cnt, exp_err);
    run_frame(CR, 8'h05, 8'h00, 1'b1);

    // Transmitter busy: ACK held back; next frame's byte stays pending.
    clear_log();
    tx_busy = 1'b1;
    ref_mem[7] = 8'h5A;
    send_byte(CW);
    send_byte(8'h07);
    send_byte(8'h5A);
`ifdef UART_BRIDGE_CHECKSUM_EN
    send_byte(CW ^ 8'h07 ^ 8'h5A);
`endif
    tick(50);
    check("busy_wr_done", wr_addr_q.size(), 1);
    check("busy_no_tx", tx_q.size(), 0);
    c0 = clr_cnt;
    rx_data = CR; rx_rdy = 1'b1;
    tick(10);
    check("busy_byte_pending", clr_cnt - c0, 0);
    tx_busy = 1'b0;
    send_byte(CR);
    check("busy_ack_sent", tx_q.size(), 1);
    if (tx_q.size() > 0) check("busy_ack_byte", tx_q[0], ACK);
    if (tx_cyc_q.size() > 0) check("busy_ack_before_take", tx_cyc_q[0] < last_clr, 1'b1);
    send_byte(8'h07);
`ifdef UART_BRIDGE_CHECKSUM_EN
    send_byte(CR ^ 8'h07);
`endif
    k = 0;
    while (tx_q.size() < 2 && k < 100) begin tick(1); k++; end
    tick(6);
    check("busy_read_reply", (tx_q.size() > 1) ? tx_q[1] : 8'hXX, 8'h5A);

    // Reset in the middle of a frame discards it.
    clear_log();
    send_byte(CW);
    send_byte(8'h03);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    ref_reset();
    tick(10);
    check("midrst_wr", wr_addr_q.size(), 0);
    check("midrst_tx", tx_q.size(), 0);
    check("midrst_err_cnt", err_cnt, 8'h00);
    run_frame(CR, 8'h03, 8'h00, 1'b1);

    // Randomised frames of every kind.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      a = 8'($urandom_range(0, 15));
      b = 8'($urandom);
      case (kind)
        0: run_frame(CW, a, b, 1'b1);
        1: run_frame(CR, a, b, 1'b1);
        2: begin
          b = 8'($urandom);
          if (b == CW || b == CR) b = 8'h00;
          run_frame(b, a, 8'h00, 1'b1);
        end
        default: run_frame((b[0] ? CW : CR), 8'($urandom_range(16, 255)), b, 1'b1);
      endcase
    end

    // Error counter saturates at 255.
    for (int n = 0; n < 260; n++) run_frame(8'h41, 8'h00, 8'h00, 1'b0);
    check("err_cnt_saturated", err_cnt, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Command responder on the host-facing side of the UART: consumes bytes delivered by the UART receiver, decodes read/write register frames sent by the remote initiator, drives a simple register bus, and returns ACK/NAK/read-data bytes through the UART transmitter. It sits between `uart_top`'s `rdy`/`data_out`/`rdy_clr` and `wr_en`/`data_in`/`busy` pins and the block's control registers.

## Interface
- `ADDR_W`, 8: implemented address bits (1..8); address byte bits above `ADDR_W` must be zero.
- `TIMEOUT_CYC`, 100000: maximum idle clocks between bytes of one frame before abort.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `rx_rdy` in 1: receiver byte available (level, held until cleared).
- `rx_data` in 8: received byte, valid while `rx_rdy`=1.
- `rx_rdy_clr` out 1: one-cycle pulse acknowledging the byte.
- `tx_wr_en` out 1: one-cycle pulse loading `tx_data` into the transmitter.
- `tx_data` out 8: byte to transmit, held stable from pulse until next pulse.
- `tx_busy` in 1: transmitter busy.
- `reg_wr` out 1: one-cycle register write strobe.
- `reg_rd` out 1: one-cycle register read strobe.
- `reg_addr` out ADDR_W: register address, stable during strobes.
- `reg_wdata` out 8: write data.
- `reg_rdata` in 8: read data, valid the cycle after `reg_rd`.
- `frame_err` out 1: one-cycle pulse on any NAK or timeout.
- `err_cnt` out 8: saturating count of `frame_err` pulses.

## Operation
- Frames: write = 0x57 ('W'), addr, data -> reply 0x06 (ACK). Read = 0x52 ('R'), addr -> reply register byte.
- Any other first byte -> immediate reply 0x15 (NAK), no further bytes consumed for that frame.
- Address with bits above `ADDR_W` set -> NAK; write not performed, no `reg_rd`.
- FSM: IDLE -> GET_ADDR -> (write) GET_DATA -> EXEC -> SEND -> SEND_WAIT -> IDLE; (read) GET_ADDR -> EXEC -> RD_WAIT -> SEND -> SEND_WAIT -> IDLE. GET_CHK inserted before EXEC when the macro is enabled.
- Byte accept: in IDLE/GET_* with `rx_rdy`=1, capture `rx_data`, pulse `rx_rdy_clr` the same cycle, ignore `rx_rdy` the following cycle.
- Bytes arriving during EXEC/RD_WAIT/SEND/SEND_WAIT stay pending in the receiver (not cleared) and are taken in IDLE.
- Timeout: counter cleared on each accepted byte, runs in GET_* states; reaching `TIMEOUT_CYC` -> IDLE, `frame_err` pulse, no reply, no register access.
- `err_cnt` increments per `frame_err`, holds at 255.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE; all outputs 0 (`tx_data`, `reg_addr`, `reg_wdata`, `err_cnt` = 0); timeout counter 0. Reset mid-frame or mid-send discards the frame; no further strobes.
- Write: final byte accepted at cycle N -> `reg_wr` at N+1 -> `tx_wr_en`(0x06) at N+2 earliest.
- Read: address accepted at N -> `reg_rd` at N+1 -> `reg_rdata` captured N+2 -> `tx_wr_en` at N+3 earliest.
- NAK: offending byte accepted at N -> `tx_wr_en`(0x15) at N+1 earliest; `frame_err` at N+1.
- SEND issues `tx_wr_en` only when `tx_busy`=0; otherwise waits. SEND_WAIT ignores `tx_busy` for one cycle after the pulse, then returns to IDLE when `tx_busy`=0.
- `reg_wr` and `reg_rd` never asserted together; at most one strobe per frame.

## Configuration
- `UART_BRIDGE_CHECKSUM_EN` defined: every request carries a trailing checksum byte = XOR of all preceding frame bytes; mismatch -> NAK, no register access. Read reply becomes two bytes: data, then XOR of 0x52, addr, data (each via SEND/SEND_WAIT). ACK/NAK unchanged.
- Undefined: no checksum byte, GET_CHK absent, single-byte read reply.

## Test plan
- Reset: hold `rst`=0 with `rx_rdy`=1 -> all outputs 0, `rx_rdy_clr` never pulses.
- Write 0x57,0x05,0xA5 -> one `reg_wr` with addr 0x05, wdata 0xA5; `tx_data`=0x06 pulse; three `rx_rdy_clr` pulses.
- Read 0x52,0x05 with `reg_rdata`=0x3C -> `reg_rd` once, `tx_data`=0x3C; with macro and trailing 0x57, reply 0x3C then 0x52^0x05^0x3C=0x6B.
- Bad command 0x41 -> NAK 0x15, `frame_err` pulse, `err_cnt`=1; with `ADDR_W`=4, write to addr 0x10 -> NAK, no `reg_wr`.
- Send 0x57,0x05 then silence `TIMEOUT_CYC` cycles -> return to IDLE, `frame_err`, no reply; following valid read succeeds.
- Hold `tx_busy`=1 for 50 cycles before ACK -> `tx_wr_en` waits until `tx_busy`=0; next frame's bytes stay pending until IDLE.
